// File: rtl/fmad_arb_pkg.sv
// Shared types and defaults for the fmad arbiter and its round-robin picker.
package fmad_arb_pkg;

    localparam int unsigned FMAD_ARB_NREQ_DEFAULT    = 4;
    localparam int unsigned FMAD_ARB_WIDTH_DEFAULT   = 11;
    localparam int unsigned FMAD_ARB_TIMEOUT_DEFAULT = 64;

    typedef enum logic [1:0] {
        FMAD_ARB_IDLE  = 2'd0,
        FMAD_ARB_ISSUE = 2'd1,
        FMAD_ARB_BUSY  = 2'd2,
        FMAD_ARB_RESP  = 2'd3
    } fmadArbState_t;

    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/fmad_arbiter_if.sv
// Request/response and fmad-side signal bundle; slave = arbiter, master = surrounding logic.
interface fmad_arbiter_if #(
    parameter int unsigned NREQ     = 4,
    parameter int unsigned WIDTH    = 11,
    parameter int unsigned OUTWIDTH = 2 * WIDTH
);
    logic [NREQ-1:0]       reqValid;
    logic [NREQ-1:0]       reqReady;
    logic [NREQ*WIDTH-1:0] reqMulIn1;
    logic [NREQ*WIDTH-1:0] reqMulIn2;
    logic [NREQ*WIDTH-1:0] reqAddIn;
    logic [NREQ-1:0]       rspValid;
    logic [OUTWIDTH-1:0]   rspData;
    logic                  rspErr;
    logic [WIDTH-1:0]      fmadMulIn1;
    logic [WIDTH-1:0]      fmadMulIn2;
    logic [WIDTH-1:0]      fmadAddIn;
    logic                  fmadStart;
    logic                  fmadClr;
    logic [OUTWIDTH-1:0]   fmadOut;
    logic                  fmadDone;
    logic                  busy;

    modport slave (
        input  reqValid, reqMulIn1, reqMulIn2, reqAddIn, fmadOut, fmadDone,
        output reqReady, rspValid, rspData, rspErr,
               fmadMulIn1, fmadMulIn2, fmadAddIn, fmadStart, fmadClr, busy
    );

    modport master (
        output reqValid, reqMulIn1, reqMulIn2, reqAddIn, fmadOut, fmadDone,
        input  reqReady, rspValid, rspData, rspErr,
               fmadMulIn1, fmadMulIn2, fmadAddIn, fmadStart, fmadClr, busy
    );
endinterface

// File: rtl/fmad_arbiter_rr_arbiter.sv
// Round-robin picker: first valid request at or above the pointer, with wrap; pointer moves past the winner on advance.
module rr_arbiter
    import fmad_arb_pkg::*;
#(
    parameter int unsigned NREQ = FMAD_ARB_NREQ_DEFAULT,
    localparam int unsigned IDXW = idx_width(NREQ)
) (
    input  logic            clock,
    input  logic            reset,
    input  logic [NREQ-1:0] req_valid,
    input  logic            advance,
    output logic [NREQ-1:0] grant,
    output logic [IDXW-1:0] grant_idx
);

    logic [IDXW-1:0] pointer;
    logic [IDXW-1:0] cand;
    logic            found;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        cand      = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            cand = IDXW'((32'(pointer) + i) % NREQ);
            if (!found && req_valid[cand]) begin
                found           = 1'b1;
                grant[cand]     = 1'b1;
                grant_idx       = cand;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pointer <= '0;
        end else if (advance) begin
            pointer <= (grant_idx == IDXW'(NREQ - 1)) ? '0 : grant_idx + 1'b1;
        end
    end

endmodule

// File: rtl/fmad_arbiter.sv
// Shares one fmad among NREQ requesters: round-robin grant, issue, wait for done, respond, clear.
// Optional busy-state watchdog enabled by defining FMAD_ARB_TIMEOUT_EN.
module fmad_arbiter
    import fmad_arb_pkg::*;
#(
    parameter int unsigned NREQ     = FMAD_ARB_NREQ_DEFAULT,
    parameter int unsigned WIDTH    = FMAD_ARB_WIDTH_DEFAULT,
    parameter int unsigned OUTWIDTH = 2 * WIDTH,
    parameter int unsigned TIMEOUT  = FMAD_ARB_TIMEOUT_DEFAULT
) (
    input  logic            clock,
    input  logic            reset,
    fmad_arbiter_if.slave   bus
);

    localparam int unsigned IDXW = idx_width(NREQ);

    if (NREQ < 2 || NREQ > 8 || TIMEOUT < 1) begin : g_bad_params
        $error("fmad_arbiter: NREQ must be 2..8 and TIMEOUT at least 1");
    end

    fmadArbState_t   state;
    logic [IDXW-1:0] grant_id;
    logic [IDXW-1:0] arb_idx;
    logic [NREQ-1:0] arb_grant;
    logic [WIDTH-1:0] mul1_q;
    logic [WIDTH-1:0] mul2_q;
    logic [WIDTH-1:0] add_q;
    logic            accept;
    logic            busy_timeout;
    logic            resp_err;

    rr_arbiter #(
        .NREQ (NREQ)
    ) u_rr (
        .clock     (clock),
        .reset     (reset),
        .req_valid (bus.reqValid),
        .advance   (accept),
        .grant     (arb_grant),
        .grant_idx (arb_idx)
    );

    assign accept = (state == FMAD_ARB_IDLE) && (|arb_grant);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state    <= FMAD_ARB_IDLE;
            grant_id <= '0;
            mul1_q   <= '0;
            mul2_q   <= '0;
            add_q    <= '0;
        end else begin
            case (state)
                FMAD_ARB_IDLE: begin
                    if (accept) begin
                        grant_id <= arb_idx;
                        mul1_q   <= bus.reqMulIn1[32'(arb_idx) * WIDTH +: WIDTH];
                        mul2_q   <= bus.reqMulIn2[32'(arb_idx) * WIDTH +: WIDTH];
                        add_q    <= bus.reqAddIn[32'(arb_idx) * WIDTH +: WIDTH];
                        state    <= FMAD_ARB_ISSUE;
                    end
                end
                FMAD_ARB_ISSUE: state <= FMAD_ARB_BUSY;
                FMAD_ARB_BUSY: begin
                    if (bus.fmadDone || busy_timeout) begin
                        state <= FMAD_ARB_RESP;
                    end
                end
                default: state <= FMAD_ARB_IDLE;
            endcase
        end
    end

`ifdef FMAD_ARB_TIMEOUT_EN
    localparam int unsigned CNTW = $clog2(TIMEOUT + 1);

    logic [CNTW-1:0] wd_count;
    logic            wd_err;

    // The count equals the number of completed BUSY cycles, so the TIMEOUT-th one ends the wait.
    assign busy_timeout = (state == FMAD_ARB_BUSY) && !bus.fmadDone &&
                          (wd_count == CNTW'(TIMEOUT - 1));

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wd_count <= '0;
            wd_err   <= 1'b0;
        end else if (state == FMAD_ARB_ISSUE) begin
            wd_count <= '0;
            wd_err   <= 1'b0;
        end else if (state == FMAD_ARB_BUSY) begin
            wd_count <= wd_count + 1'b1;
            if (busy_timeout) begin
                wd_err <= 1'b1;
            end
        end
    end

    assign resp_err = wd_err;
`else
    assign busy_timeout = 1'b0;
    assign resp_err     = 1'b0;
`endif

    // reqReady is gated by reset so a held reqValid cannot leak a grant while reset is asserted.
    assign bus.reqReady = (state == FMAD_ARB_IDLE && !reset) ? arb_grant : '0;

    always_comb begin
        bus.rspValid = '0;
        if (state == FMAD_ARB_RESP) begin
            bus.rspValid[grant_id] = 1'b1;
        end
    end

    assign bus.rspData    = (state == FMAD_ARB_RESP && !resp_err) ? bus.fmadOut : '0;
    assign bus.rspErr     = (state == FMAD_ARB_RESP) && resp_err;
    assign bus.fmadMulIn1 = mul1_q;
    assign bus.fmadMulIn2 = mul2_q;
    assign bus.fmadAddIn  = add_q;
    assign bus.fmadStart  = (state == FMAD_ARB_ISSUE);
    assign bus.fmadClr    = reset || (state == FMAD_ARB_RESP);
    assign bus.busy       = (state != FMAD_ARB_IDLE);

endmodule

// File: tb/tb_fmad_arbiter.sv
// Directed bench for fmad_arbiter with a behavioural fixed-latency fmad; honours FMAD_ARB_TIMEOUT_EN.
module tb_fmad_arbiter;

    localparam int unsigned NREQ     = 4;
    localparam int unsigned WIDTH    = 11;
    localparam int unsigned OUTWIDTH = 2 * WIDTH;
    localparam int unsigned TIMEOUT  = 8;
    localparam int unsigned LAT      = 3;

    logic clock;
    logic reset;
    logic hang;
    int   checks;
    int   errors;

    fmad_arbiter_if #(.NREQ(NREQ), .WIDTH(WIDTH), .OUTWIDTH(OUTWIDTH)) bus ();

    fmad_arbiter #(
        .NREQ     (NREQ),
        .WIDTH    (WIDTH),
        .OUTWIDTH (OUTWIDTH),
        .TIMEOUT  (TIMEOUT)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // fmad model: done rises LAT edges after the start edge and stays until cleared.
    int unsigned fm_cnt;
    logic        fm_active;
    always @(posedge clock) begin
        if (bus.fmadClr) begin
            bus.fmadDone <= 1'b0;
            bus.fmadOut  <= '0;
            fm_active    <= 1'b0;
            fm_cnt       <= 0;
        end else if (bus.fmadStart) begin
            fm_active   <= 1'b1;
            fm_cnt      <= LAT;
            bus.fmadOut <= OUTWIDTH'(bus.fmadMulIn1) * OUTWIDTH'(bus.fmadMulIn2)
                           + OUTWIDTH'(bus.fmadAddIn);
        end else if (fm_active && !hang) begin
            if (fm_cnt == 1) begin
                bus.fmadDone <= 1'b1;
                fm_active    <= 1'b0;
            end
            fm_cnt <= fm_cnt - 1;
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int unsigned r, input int unsigned a, input int unsigned b,
                           input int unsigned c);
        bus.reqMulIn1[r*WIDTH +: WIDTH] = WIDTH'(a);
        bus.reqMulIn2[r*WIDTH +: WIDTH] = WIDTH'(b);
        bus.reqAddIn[r*WIDTH +: WIDTH]  = WIDTH'(c);
    endtask

    // Advances until rspValid is seen; while busy the arbiter must not offer a grant.
    task automatic wait_rsp(input string tag, output int unsigned n);
        n = 0;
        while (bus.rspValid == '0 && n < 200) begin
            if (bus.busy) check({tag, "_ready_while_busy"}, 64'(bus.reqReady), 64'd0);
            tick();
            n++;
        end
        if (bus.rspValid == '0) begin
            checks++;
            errors++;
            $error("FAIL %s_rsp_timeout observed=no rspValid expected=rspValid within 200 cycles", tag);
        end
    endtask

    logic [3:0]  onehot;
    logic [21:0] exp_res [4];
    int unsigned n;
    int unsigned bad;

    initial begin
        checks  = 0;
        errors  = 0;
        hang    = 1'b0;
        reset   = 1'b1;
        bus.reqValid  = '0;
        bus.reqMulIn1 = '0;
        bus.reqMulIn2 = '0;
        bus.reqAddIn  = '0;
        exp_res[0] = 22'd6;
        exp_res[1] = 22'd10;
        exp_res[2] = 22'd14;
        exp_res[3] = 22'd18;

        tick();
        tick();
        check("rst_reqReady", 64'(bus.reqReady), 64'd0);
        check("rst_rspValid", 64'(bus.rspValid), 64'd0);
        check("rst_rspData", 64'(bus.rspData), 64'd0);
        check("rst_rspErr", 64'(bus.rspErr), 64'd0);
        check("rst_fmadStart", 64'(bus.fmadStart), 64'd0);
        check("rst_fmadClr", 64'(bus.fmadClr), 64'd1);
        check("rst_busy", 64'(bus.busy), 64'd0);
        check("rst_fmadMulIn1", 64'(bus.fmadMulIn1), 64'd0);
        reset = 1'b0;
        #1;
        check("rst_release_clr", 64'(bus.fmadClr), 64'd0);

        // Single request: 3*5+7 = 22
        set_req(2, 3, 5, 7);
        bus.reqValid = 4'b0100;
        #1;
        check("t1_ready", 64'(bus.reqReady), 64'h4);
        tick();
        bus.reqValid = '0;
        check("t1_ready_after", 64'(bus.reqReady), 64'd0);
        check("t1_start", 64'(bus.fmadStart), 64'd1);
        check("t1_busy", 64'(bus.busy), 64'd1);
        check("t1_mul1", 64'(bus.fmadMulIn1), 64'd3);
        check("t1_mul2", 64'(bus.fmadMulIn2), 64'd5);
        check("t1_add", 64'(bus.fmadAddIn), 64'd7);
        tick();
        check("t1_start_once", 64'(bus.fmadStart), 64'd0);
        wait_rsp("t1", n);
        // acceptance edge + ISSUE edge + LAT fmad edges + done-seen edge: n counts from the ISSUE edge
        check("t1_latency", 64'(n + 1), 64'(LAT + 2));
        check("t1_rspValid", 64'(bus.rspValid), 64'h4);
        check("t1_rspData", 64'(bus.rspData), 64'd22);
        check("t1_rspErr", 64'(bus.rspErr), 64'd0);
        check("t1_clr", 64'(bus.fmadClr), 64'd1);
        check("t1_mul1_stable", 64'(bus.fmadMulIn1), 64'd3);
        tick();
        check("t1_rsp_pulse", 64'(bus.rspValid), 64'd0);
        check("t1_clr_pulse", 64'(bus.fmadClr), 64'd0);
        check("t1_idle", 64'(bus.busy), 64'd0);

        // Contention from a fresh pointer: grants 0,1,2,3,0
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int unsigned i = 0; i < NREQ; i++) set_req(i, i + 2, 3, i);
        bus.reqValid = 4'b1111;
        #1;
        for (int unsigned k = 0; k < 5; k++) begin
            onehot = 4'b0001 << (k % 4);
            check("t2_grant", 64'(bus.reqReady), 64'(onehot));
            check("t2_onehot", 64'($countones(bus.reqReady) <= 1), 64'd1);
            tick();
            wait_rsp("t2", n);
            check("t2_rspValid", 64'(bus.rspValid), 64'(onehot));
            check("t2_rspData", 64'(bus.rspData), 64'(exp_res[k % 4]));
            tick();
        end
        bus.reqValid = '0;

        // Back-to-back from requester 1: 2*2+1 = 5, then 10*10+0 = 100
        set_req(1, 2, 2, 1);
        bus.reqValid = 4'b0010;
        #1;
        check("t3_ready", 64'(bus.reqReady), 64'h2);
        tick();
        set_req(1, 10, 10, 0);
        wait_rsp("t3a", n);
        check("t3_rspValid1", 64'(bus.rspValid), 64'h2);
        check("t3_rspData1", 64'(bus.rspData), 64'd5);
        tick();
        check("t3_regrant", 64'(bus.reqReady), 64'h2);
        check("t3_no_start_idle", 64'(bus.fmadStart), 64'd0);
        tick();
        bus.reqValid = '0;
        check("t3_start2", 64'(bus.fmadStart), 64'd1);
        check("t3_mul1_2", 64'(bus.fmadMulIn1), 64'd10);
        wait_rsp("t3b", n);
        check("t3_rspData2", 64'(bus.rspData), 64'd100);
        tick();

        // Withdraw: requester 3 asks while busy and leaves before IDLE; 4*4+4 = 20
        set_req(0, 4, 4, 4);
        bus.reqValid = 4'b0001;
        #1;
        check("t4_ready0", 64'(bus.reqReady), 64'h1);
        tick();
        bus.reqValid = '0;
        tick();
        set_req(3, 1, 1, 1);
        bus.reqValid = 4'b1000;
        #1;
        check("t4_no_ready_busy", 64'(bus.reqReady), 64'd0);
        tick();
        bus.reqValid = '0;
        wait_rsp("t4", n);
        check("t4_rspValid", 64'(bus.rspValid), 64'h1);
        check("t4_rspData", 64'(bus.rspData), 64'd20);
        bad = 0;
        for (int unsigned k = 0; k < 4; k++) begin
            tick();
            if (bus.rspValid != '0 || bus.busy) bad++;
        end
        check("t4_never_granted", 64'(bad), 64'd0);

        // Reset in BUSY: 6*7+8 would be 50 but must be abandoned
        set_req(2, 6, 7, 8);
        bus.reqValid = 4'b0100;
        #1;
        tick();
        bus.reqValid = '0;
        tick();
        tick();
        check("t5_in_busy", 64'(bus.busy), 64'd1);
        reset = 1'b1;
        bus.reqValid = 4'b0110;
        #1;
        check("t5_busy", 64'(bus.busy), 64'd0);
        check("t5_rspValid", 64'(bus.rspValid), 64'd0);
        check("t5_start", 64'(bus.fmadStart), 64'd0);
        check("t5_mul1", 64'(bus.fmadMulIn1), 64'd0);
        check("t5_ready", 64'(bus.reqReady), 64'd0);
        check("t5_clr", 64'(bus.fmadClr), 64'd1);
        tick();
        check("t5_rspValid_hold", 64'(bus.rspValid), 64'd0);
        tick();
        reset = 1'b0;
        set_req(0, 7, 7, 7);
        bus.reqValid = 4'b1111;
        #1;
        check("t5_ptr_reset", 64'(bus.reqReady), 64'h1);
        tick();
        bus.reqValid = '0;
        wait_rsp("t5", n);
        check("t5_rspValid_after", 64'(bus.rspValid), 64'h1);
        check("t5_rspData_after", 64'(bus.rspData), 64'd56);
        tick();

        // fmad that never finishes
        hang = 1'b1;
        set_req(1, 1, 2, 3);
        bus.reqValid = 4'b0010;
        #1;
        tick();
        bus.reqValid = '0;
`ifdef FMAD_ARB_TIMEOUT_EN
        tick();
        n = 0;
        while (bus.rspValid == '0 && n < 100) begin
            tick();
            n++;
        end
        check("t6_timeout_cycles", 64'(n), 64'(TIMEOUT));
        check("t6_rspErr", 64'(bus.rspErr), 64'd1);
        check("t6_rspData", 64'(bus.rspData), 64'd0);
        check("t6_rspValid", 64'(bus.rspValid), 64'h2);
        check("t6_clr", 64'(bus.fmadClr), 64'd1);
        tick();
        check("t6_idle", 64'(bus.busy), 64'd0);
        check("t6_err_pulse", 64'(bus.rspErr), 64'd0);
`else
        bad = 0;
        for (int unsigned k = 0; k < 100; k++) begin
            tick();
            if (!bus.busy || bus.rspValid != '0) bad++;
        end
        check("t6_stuck_busy", 64'(bad), 64'd0);
        check("t6_rspErr", 64'(bus.rspErr), 64'd0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
        check("t6_recover", 64'(bus.busy), 64'd0);
`endif
        hang = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_watchdog observed=still running expected=finished");
        $fatal(1, "simulation did not finish");
    end

endmodule
